// File: rtl/shift_pla_pkg.sv
// Shared types, default geometry and a one-lane reference model for the
// shift-only tanh/sigmoid pipeline.
package shift_pla_pkg;

    typedef enum logic {
        ACT_TANH    = 1'b0,
        ACT_SIGMOID = 1'b1
    } act_mode_e;

    localparam int LATENCY       = 3;
    localparam int DEF_W_IN      = 8;
    localparam int DEF_IN_I      = 3;
    localparam int DEF_W_OUT     = 8;
    localparam int DEF_LANES     = 4;
    localparam int DEF_SAT_SHIFT = 6;
    localparam int DEF_CNT_W     = 16;

    typedef struct packed {
        logic [DEF_W_OUT-1:0] y;
        logic                 sat;
    } lane_ref_t;

    // Integer model of one lane at the default geometry.
    function automatic lane_ref_t lane_ref(input logic [DEF_W_IN-1:0] x, input act_mode_e mode);
        lane_ref_t res;
        int f, of, xs, a, t, m, rf, r, y, v, o;
        logic s;
        f  = DEF_W_IN - DEF_IN_I;
        of = DEF_W_OUT - 1;
        s  = x[DEF_W_IN-1];
        xs = int'(signed'(x));
        a  = s ? -xs : xs;
        t  = (mode == ACT_TANH) ? 2 * a : a;
        m  = t >> f;
        rf = t % (1 << f);
        r  = (of >= f) ? (rf << (of - f)) : (rf >> (f - of));
        y  = (1 << of) - ((1 << of) >> m) + (r >> (m + 1));
        res.sat = (m >= DEF_SAT_SHIFT);
        v  = s ? -y : y;
        if (mode == ACT_TANH)
            o = res.sat ? (s ? -(1 << of) : (1 << of) - 1) : v;
        else
            o = res.sat ? (s ? 0 : (1 << of) - 1) : (1 << (of - 1)) + (v >>> 1);
        res.y = o[DEF_W_OUT-1:0];
        return res;
    endfunction

endpackage

// File: rtl/shift_pla_pipe_lane.sv
// One lane of the piecewise-linear activation: three register stages sharing
// a single enable, no multipliers.
module shift_pla_lane
    import shift_pla_pkg::*;
#(
    parameter int W_IN      = DEF_W_IN,
    parameter int IN_I      = DEF_IN_I,
    parameter int W_OUT     = DEF_W_OUT,
    parameter int SAT_SHIFT = DEF_SAT_SHIFT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  act_mode_e        mode_s1_i,
    input  act_mode_e        mode_s3_i,
    input  logic [W_IN-1:0]  x_i,
    output logic [W_OUT-1:0] y_o,
    output logic             sat_o
);
    localparam int F  = W_IN - IN_I;
    localparam int OF = W_OUT - 1;
    localparam int TW = W_IN + 1;
    localparam int MW = TW - F;

    localparam logic [OF:0]      Y_ONE   = {1'b1, {OF{1'b0}}};
    localparam logic [W_OUT-1:0] POS_MAX = {1'b0, {OF{1'b1}}};
    localparam logic [W_OUT-1:0] NEG_ONE = {1'b1, {OF{1'b0}}};
    localparam logic [W_OUT-1:0] HALF    = {2'b01, {(OF-1){1'b0}}};

    logic [W_IN-1:0]  abs_x;
    logic [TW-1:0]    t;
    logic             s1_sign_d, s1_sign_q;
    logic [MW-1:0]    s1_m_d, s1_m_q;
    logic [OF-1:0]    s1_r_d, s1_r_q;
    logic             s2_sign_d, s2_sign_q;
    logic             s2_sat_d, s2_sat_q;
    logic [OF:0]      s2_y_d, s2_y_q;
    logic [W_OUT-1:0] y_signed;
    logic [W_OUT-1:0] y3_d, y3_q;
    logic             sat3_d, sat3_q;

    // Stage 1: magnitude (-2^(W_IN-1) maps to 2^(W_IN-1) as unsigned), scale, split into m and r
    always_comb begin
        s1_sign_d = x_i[W_IN-1];
        abs_x     = s1_sign_d ? -x_i : x_i;
        t         = (mode_s1_i == ACT_TANH) ? {abs_x, 1'b0} : {1'b0, abs_x};
        s1_m_d    = t[TW-1:F];
        s1_r_d    = OF'({t[F-1:0], {OF{1'b0}}} >> F);
    end

    // Stage 2: y = 1 - 2^-m + r*2^-(m+1), built from shifts only
    always_comb begin
        s2_sign_d = s1_sign_q;
        s2_sat_d  = (int'(s1_m_q) >= SAT_SHIFT);
        s2_y_d    = Y_ONE - (Y_ONE >> s1_m_q) + (({1'b0, s1_r_q} >> s1_m_q) >> 1);
    end

    // Stage 3: apply sign and, for sigmoid, fold into 0.5 + y/2
    always_comb begin
        y_signed = s2_sign_q ? -s2_y_q : s2_y_q;
        y3_d     = y_signed;
        sat3_d   = s2_sat_q;
        if (mode_s3_i == ACT_TANH) begin
            if (s2_sat_q) y3_d = s2_sign_q ? NEG_ONE : POS_MAX;
        end else begin
            if (s2_sat_q) y3_d = s2_sign_q ? '0 : POS_MAX;
            else          y3_d = HALF + {y_signed[W_OUT-1], y_signed[W_OUT-1:1]};
        end
    end

    // Pipeline registers, all frozen together when the shared enable is low
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_sign_q <= 1'b0;
            s1_m_q    <= '0;
            s1_r_q    <= '0;
            s2_sign_q <= 1'b0;
            s2_sat_q  <= 1'b0;
            s2_y_q    <= '0;
            y3_q      <= '0;
            sat3_q    <= 1'b0;
        end else if (en_i) begin
            s1_sign_q <= s1_sign_d;
            s1_m_q    <= s1_m_d;
            s1_r_q    <= s1_r_d;
            s2_sign_q <= s2_sign_d;
            s2_sat_q  <= s2_sat_d;
            s2_y_q    <= s2_y_d;
            y3_q      <= y3_d;
            sat3_q    <= sat3_d;
        end
    end

    assign y_o   = y3_q;
    assign sat_o = sat3_q;

endmodule

// File: rtl/shift_pla_pipe.sv
// Multi-lane streaming tanh/sigmoid unit: valid/mode pipeline, handshake and
// saturation event counter around LANES copies of the lane datapath.
module shift_pla_pipe
    import shift_pla_pkg::*;
#(
    parameter int W_IN      = DEF_W_IN,
    parameter int IN_I      = DEF_IN_I,
    parameter int W_OUT     = DEF_W_OUT,
    parameter int LANES     = DEF_LANES,
    parameter int SAT_SHIFT = DEF_SAT_SHIFT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*W_IN-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W_OUT-1:0] out_data,
    output logic [CNT_W-1:0]       sat_count,
    input  logic                   cnt_clear
);
    logic             en;
    logic             v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    act_mode_e        mode1_d, mode1_q, mode2_d, mode2_q;
    logic [LANES-1:0] lane_sat;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // The whole pipe advances only when the output slot is free or being drained
    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign sat_count = cnt_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        shift_pla_lane #(
            .W_IN      (W_IN),
            .IN_I      (IN_I),
            .W_OUT     (W_OUT),
            .SAT_SHIFT (SAT_SHIFT)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .en_i      (en),
            .mode_s1_i (act_mode_e'(in_mode)),
            .mode_s3_i (mode2_q),
            .x_i       (in_data[k*W_IN +: W_IN]),
            .y_o       (out_data[k*W_OUT +: W_OUT]),
            .sat_o     (lane_sat[k])
        );
    end

    // Valid and mode travel alongside the lane data; mode2 steers stage 3
    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        mode1_d = mode1_q;
        mode2_d = mode2_q;
        if (en) begin
            v1_d    = in_valid;
            v2_d    = v1_q;
            v3_d    = v2_q;
            mode1_d = act_mode_e'(in_mode);
            mode2_d = mode1_q;
        end
    end

    // Saturation counter: add saturated lanes of each emitted beat, clamp at all-ones, clear wins
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int k = 0; k < LANES; k++)
            cnt_sum = cnt_sum + {{CNT_W{1'b0}}, lane_sat[k]};
        cnt_d = cnt_q;
        if (cnt_clear)
            cnt_d = '0;
        else if (v3_q && out_ready)
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Control state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= ACT_TANH;
            mode2_q <= ACT_TANH;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_pla_pipe.sv
// Directed and random-backpressure bench for shift_pla_pipe with a scoreboard.
module tb_shift_pla_pipe;
    import shift_pla_pkg::*;

    localparam int LANES = DEF_LANES;
    localparam int W_IN  = DEF_W_IN;
    localparam int W_OUT = DEF_W_OUT;
    localparam int CNT_W = DEF_CNT_W;
    localparam int DW    = LANES * W_IN;
    localparam int OW    = LANES * W_OUT;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CNT_W-1:0] sat_count;
    logic          cnt_clear;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [3:0]    nsat;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            model_cnt;
    logic          rand_rdy;
    logic          prev_stall;
    logic [OW-1:0] prev_data;

    always #5 clock = ~clock;

    shift_pla_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_count (sat_count),
        .cnt_clear (cnt_clear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [OW-1:0] d, input logic [3:0] n);
        exp_t e;
        e.data = d;
        e.nsat = n;
        return e;
    endfunction

    function automatic exp_t model_beat(input logic mode, input logic [DW-1:0] d);
        exp_t      e;
        lane_ref_t r;
        e.data = '0;
        e.nsat = '0;
        for (int k = 0; k < LANES; k++) begin
            r = lane_ref(d[k*W_IN +: W_IN], act_mode_e'(mode));
            e.data[k*W_OUT +: W_OUT] = r.y;
            e.nsat = e.nsat + 4'(r.sat);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic mode, input logic [DW-1:0] d, input exp_t e);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        sb.push_back(e);
        for (int n = 0; n < 1000 && !acc; n++) begin
            @(negedge clock);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic monitor_step();
        exp_t e;
        int   s;
        if (reset) begin
            sb.delete();
            model_cnt  = 0;
            prev_stall = 1'b0;
            return;
        end
        chk("sat_count", 64'(sat_count), 64'(model_cnt));
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        s = model_cnt;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                s = model_cnt + int'(e.nsat);
                if (s > MAXC) s = MAXC;
            end
        end
        model_cnt  = cnt_clear ? 0 : s;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_mode    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        cnt_clear  = 1'b0;
        rand_rdy   = 1'b0;
        model_cnt  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        fork
            forever begin
                @(negedge clock);
                monitor_step();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);

        // tanh basics with latency: lanes {0x00,0xE0,0x20,0x08} -> {0x00,0xA0,0x60,0x20}
        send(1'b0, 32'h00E02008, mk(32'h00A06020, 4'd0));
        chk("lat_c1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_c2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_c3", 64'(out_valid), 64'd1);

        // tanh saturation (+2 sat), sigmoid, segment-boundary tanh values, back to back
        send(1'b0, 32'h08088060, mk(32'h2020807F, 4'd2));
        // sigmoid(-4.0) lands at m=4, below saturation: 0.5 - 120/256 -> 0x04
        send(1'b1, 32'h80C04000, mk(32'h04107040, 4'd0));
        send(1'b0, 32'h7F5FB050, mk(32'h7F7D847C, 4'd1));
        drain();

        // Stall with two beats in flight
        out_ready = 1'b0;
        send(1'b0, 32'h00E02008, mk(32'h00A06020, 4'd0));
        send(1'b1, 32'h80C04000, mk(32'h04107040, 4'd0));
        tick();
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) tick();
        out_ready = 1'b1;
        drain();

        // Random beats under 50% backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic          m;
            logic [DW-1:0] d;
            m = 1'($urandom_range(0, 1));
            d = DW'($urandom());
            if ($urandom_range(0, 3) == 0) tick();
            send(m, d, model_beat(m, d));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three saturating beats in flight
        send(1'b0, 32'h08088060, mk(32'h2020807F, 4'd2));
        send(1'b0, 32'h08088060, mk(32'h2020807F, 4'd2));
        send(1'b0, 32'h08088060, mk(32'h2020807F, 4'd2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("inflight_rst_valid", 64'(out_valid), 64'd0);
        chk("inflight_rst_count", 64'(sat_count), 64'd0);
        repeat (6) tick();

        // Drive the counter into its ceiling and beyond
        for (int i = 0; i < (MAXC + 1) / 4 + 3; i++)
            send(1'b0, 32'h80808080, mk(32'h80808080, 4'd4));
        drain();
        chk("sat_hold", 64'(sat_count), 64'(MAXC));

        // Clear coinciding with an increment
        send(1'b0, 32'h80808080, mk(32'h80808080, 4'd4));
        tick();
        tick();
        chk("clr_beat_valid", 64'(out_valid), 64'd1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clear_wins", 64'(sat_count), 64'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
